// File: rtl/pc_fetch_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_fetch_seq_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [15:0] PC_INC       = 16'd2;
  localparam logic [15:0] PC_RESET_DFLT = 16'h0000;

  // Instructions are halfword aligned; branch targets drop bit 0.
  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_fetch_sat_cnt.sv
// Saturating up-counter with increment enable; holds at all-ones.
module pc_fetch_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count enabled events, stopping at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// Fetch-stage sequencer: owns the PC, issues instruction-memory requests,
// applies decode redirects/halts and drives IF/ID valid and flush.
// Optional PC_FETCH_SEQ_PERF_EN adds redirect_cnt / stall_cnt outputs.
module pc_fetch_seq
  import pc_fetch_seq_pkg::*;
#(
  parameter logic [15:0] PC_RESET = PC_RESET_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  input  logic        halt_in,
  output logic        if_valid,
  output logic [15:0] pc_plus2,
  output logic        flush,
  output logic        halted
`ifdef PC_FETCH_SEQ_PERF_EN
  ,
  output logic [15:0] redirect_cnt,
  output logic [15:0] stall_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  pend_q, pend_d;
  logic         if_valid_c;
  logic         flush_c;
  logic [15:0]  tgt_aligned;

  assign tgt_aligned = align_pc(redirect_target);

  // State, PC and pending-target registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state / next-PC decision and per-cycle IF/ID controls.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    if_valid_c = 1'b0;
    flush_c    = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          flush_c = 1'b1;
          if (imem_ready) begin
            pc_d = tgt_aligned;
          end else begin
            pend_d  = tgt_aligned;
            state_d = DRAIN;
          end
        end else if (halt_in) begin
          flush_c = 1'b1;
          state_d = HALTED;
        end else if (stall_in) begin
          pc_d = pc_q;
        end else if (imem_ready) begin
          if_valid_c = 1'b1;
          pc_d       = pc_q + PC_INC;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          flush_c = 1'b1;
          pend_d  = tgt_aligned;
        end
        // A redirect arriving with the miss return wins over the stored target.
        if (imem_ready) begin
          pc_d    = redirect_valid ? tgt_aligned : pend_q;
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign imem_req  = rst_n && (state_q != HALTED);
  assign imem_addr = pc_q;
  assign pc_plus2  = pc_q + PC_INC;
  assign if_valid  = rst_n && if_valid_c;
  assign flush     = rst_n && flush_c;
  assign halted    = (state_q == HALTED);

`ifdef PC_FETCH_SEQ_PERF_EN
  logic redirect_inc;
  logic stall_inc;

  assign redirect_inc = redirect_valid && (state_q != HALTED);
  assign stall_inc    = (state_q == FETCH) && !if_valid_c && !flush_c;

  pc_fetch_sat_cnt #(.W(16)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_inc),
    .cnt   (redirect_cnt)
  );

  pc_fetch_sat_cnt #(.W(16)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Scoreboard bench for pc_fetch_seq: stimulus pushes expected outputs from a
// behavioural model; a negedge monitor pops and compares.
module tb_pc_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ready = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        halt_in = 1'b0;
  logic [15:0] redirect_target = '0;
  logic        imem_req, if_valid, flush, halted;
  logic [15:0] imem_addr, pc_plus2;
`ifdef PC_FETCH_SEQ_PERF_EN
  logic [15:0] redirect_cnt, stall_cnt;
`endif

  pc_fetch_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_ready      (imem_ready),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_in         (halt_in),
    .if_valid        (if_valid),
    .pc_plus2        (pc_plus2),
    .flush           (flush),
    .halted          (halted)
`ifdef PC_FETCH_SEQ_PERF_EN
    ,
    .redirect_cnt    (redirect_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic        fl;
    logic        hlt;
    logic [15:0] p2;
    logic [15:0] rc;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Behavioural model of the fetch sequencer.
  logic [15:0] m_pc, m_pend;
  bit          m_drain, m_halt;
  int unsigned m_rc, m_sc;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_pend = 16'h0000; m_drain = 0; m_halt = 0; m_rc = 0; m_sc = 0;
  endtask

  // Drive one cycle of inputs, record expected outputs, advance the model.
  task automatic cycle(input bit rdy, input bit st, input bit rv, input logic [15:0] tgt, input bit hl);
    exp_t e;
    logic [15:0] t;
    imem_ready = rdy; stall_in = st; redirect_valid = rv; redirect_target = tgt; halt_in = hl;
    t = tgt & 16'hFFFE;
    e.req  = !m_halt;
    e.addr = m_pc;
    e.p2   = m_pc + 16'd2;
    e.hlt  = m_halt;
    e.vld  = 1'b0;
    e.fl   = 1'b0;
    e.rc   = 16'(m_rc);
    e.sc   = 16'(m_sc);
    if (!m_halt) begin
      if (m_drain) e.fl = rv;
      else begin
        e.fl  = rv || hl;
        e.vld = !rv && !hl && !st && rdy;
      end
    end
    q.push_back(e);
    if (!m_halt && rv && m_rc < 65535) m_rc++;
    if (!m_halt && !m_drain && !e.vld && !e.fl && m_sc < 65535) m_sc++;
    if (m_halt) begin
    end else if (m_drain) begin
      if (rv) m_pend = t;
      if (rdy) begin m_pc = m_pend; m_drain = 0; end
    end else if (rv) begin
      if (rdy) m_pc = t;
      else begin m_pend = t; m_drain = 1; end
    end else if (hl) begin
      m_halt = 1;
    end else if (!st && rdy) begin
      m_pc = m_pc + 16'd2;
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    imem_ready = 0; stall_in = 0; redirect_valid = 0; halt_in = 0;
    rst_n = 1'b0;
    #1;
    check("rst_imem_req", {15'd0, imem_req}, 16'd0);
    check("rst_if_valid", {15'd0, if_valid}, 16'd0);
    check("rst_flush", {15'd0, flush}, 16'd0);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_pc", imem_addr, 16'h0000);
`ifdef PC_FETCH_SEQ_PERF_EN
    check("rst_redirect_cnt", redirect_cnt, 16'd0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("imem_req", {15'd0, imem_req}, {15'd0, e.req});
      check("imem_addr", imem_addr, e.addr);
      check("if_valid", {15'd0, if_valid}, {15'd0, e.vld});
      check("flush", {15'd0, flush}, {15'd0, e.fl});
      check("halted", {15'd0, halted}, {15'd0, e.hlt});
      if (e.vld) check("pc_plus2", pc_plus2, e.p2);
`ifdef PC_FETCH_SEQ_PERF_EN
      check("redirect_cnt", redirect_cnt, e.rc);
      check("stall_cnt", stall_cnt, e.sc);
`endif
    end
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    pulse_reset();

    // Sequential fetch from reset.
    repeat (3) cycle(1, 0, 0, 16'h0, 0);

    // Redirect hit with odd target.
    cycle(1, 0, 1, 16'h000A, 0);
    cycle(1, 0, 1, 16'h0009, 0);
    cycle(1, 0, 0, 16'h0, 0);

    // Redirect during miss; stall/halt ignored while draining.
    cycle(1, 0, 1, 16'h0010, 0);
    cycle(0, 0, 1, 16'h0100, 0);
    cycle(0, 1, 0, 16'h0, 1);
    cycle(1, 0, 0, 16'h0, 0);
    cycle(1, 0, 0, 16'h0, 0);

    // Stall and wrap at the top of memory.
    cycle(1, 0, 1, 16'hFFFE, 0);
    cycle(1, 1, 0, 16'h0, 0);
    cycle(1, 1, 0, 16'h0, 0);
    cycle(1, 0, 0, 16'h0, 0);
    cycle(1, 0, 0, 16'h0, 0);

    // Newer redirect replaces the pending target.
    cycle(0, 0, 1, 16'h0200, 0);
    cycle(0, 0, 1, 16'h0301, 0);
    cycle(1, 0, 0, 16'h0, 0);
    cycle(1, 0, 0, 16'h0, 0);

    // Reset in the middle of a drain.
    cycle(0, 0, 1, 16'h0400, 0);
    pulse_reset();
    cycle(1, 0, 0, 16'h0, 0);

    // Redirect beats halt, then halt and frozen state.
    cycle(1, 0, 1, 16'h0064, 1);
    cycle(1, 0, 0, 16'h0, 1);
    cycle(1, 0, 1, 16'h1234, 0);
    cycle(0, 0, 1, 16'h5678, 0);
    cycle(1, 1, 0, 16'h0, 1);
    pulse_reset();
    cycle(1, 0, 0, 16'h0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
              $urandom_range(0, 9) == 0, 16'($urandom), $urandom_range(0, 29) == 0);
      end
    end

`ifdef PC_FETCH_SEQ_PERF_EN
    // Drive the stall counter into saturation.
    pulse_reset();
    for (int i = 0; i < 65540; i++) cycle(1, 1, 0, 16'h0, 0);
    cycle(1, 1, 0, 16'h0, 0);
`endif

    @(negedge clk); #1;
    check("scoreboard_drained", 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
